ds_pixel_fetch: RTL and testbench

Read-side engine of the downscaler: after `start_proc_pulse`, it walks the source image held in the shared 8-bit SRAM and fetches the 2×2 neighbourhood for each destination pixel of a fixed 2:1 downscale. Each neighbourhood is presented on a valid/ready stream to the interpolation datapath. It is the consumer of the image that the JTAG front-end writes into memory, and it shares the SRAM port through an external arbiter (`mem_req`/`mem_gnt`). It honours the JTAG stepping controls so a run can be advanced one destination pixel at a time.

---
 rtl/ds_pkg.sv | 6 +
 rtl/ds_addr_gen.sv | 40 ++++
 rtl/ds_pixel_fetch.sv | 107 ++++++++++
 tb/tb_ds_pixel_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// ds_pkg: shared types for the downscaler pixel fetch engine.
package ds_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_STEP, FETCH, DRAIN, EMIT, DONE} ds_fetch_state_t;
  typedef logic [1:0] tap_t;
  typedef logic [7:0] pix_t;
endpackage

// File: rtl/ds_addr_gen.sv
// ds_addr_gen: destination x/y counters and 2x2 tap address generation.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int SRC_W     = 16,
  parameter int SRC_H     = 16,
  parameter int BASE_ADDR = 0,
  parameter int XW        = 3,
  parameter int YW        = 3
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [1:0]           tap,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic                 last,
  output logic [ADDR_BITS-1:0] addr
);
  logic x_end, y_end;
  assign x_end = 32'(x) == SRC_W / 2 - 1;
  assign y_end = 32'(y) == SRC_H / 2 - 1;
  assign last  = x_end && y_end;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= x_end ? '0 : x + XW'(1);
      y <= !x_end ? y : y_end ? '0 : y + YW'(1);
    end
  // truncation to ADDR_BITS gives the modulo wrap-around
  assign addr = ADDR_BITS'(32'(BASE_ADDR) + (32'(y) * 2 + 32'(tap[1])) * 32'(SRC_W)
                          + 32'(x) * 2 + 32'(tap[0]));
endmodule

// File: rtl/ds_pixel_fetch.sv
// ds_pixel_fetch: fetches 2x2 source neighbourhoods for a 2:1 downscale.
// Define DS_FETCH_STEP_EN to compile in single-step gating (WAIT_STEP).
module ds_pixel_fetch
  import ds_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int SRC_W     = 16,
  parameter int SRC_H     = 16,
  parameter int BASE_ADDR = 0,
  localparam int XW = SRC_W > 2 ? $clog2(SRC_W / 2) : 1,
  localparam int YW = SRC_H > 2 ? $clog2(SRC_H / 2) : 1
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 start_proc_pulse,
  input  logic                 step_mode,
  input  logic                 step_pulse,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_data_out,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic [7:0]           px00,
  output logic [7:0]           px01,
  output logic [7:0]           px10,
  output logic [7:0]           px11,
  output logic [XW-1:0]        px_x,
  output logic [YW-1:0]        px_y,
  output logic                 busy,
  output logic                 done
);
  if (SRC_W < 2 || SRC_W % 2 != 0 || SRC_H < 2 || SRC_H % 2 != 0) begin : g_dim_chk
    $error("ds_pixel_fetch: SRC_W and SRC_H must be even and >= 2");
  end
  if (SRC_W * SRC_H > 2 ** ADDR_BITS) begin : g_size_chk
    $error("ds_pixel_fetch: source image does not fit the address space");
  end
  ds_fetch_state_t state, state_nx;
  tap_t tap, cap_k;
  logic cap_v, clear, advance, last, gate;
  logic [ADDR_BITS-1:0] tap_addr, last_addr;
`ifdef DS_FETCH_STEP_EN
  assign gate = step_mode;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_pulse;
  assign gate = 1'b0;
`endif
  ds_addr_gen #(
    .ADDR_BITS(ADDR_BITS), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .BASE_ADDR(BASE_ADDR), .XW(XW), .YW(YW)
  ) u_addr_gen (
    .clk(clk), .aclr_n(aclr_n), .clear(clear), .advance(advance), .tap(tap),
    .x(px_x), .y(px_y), .last(last), .addr(tap_addr)
  );
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE, DONE: begin
        clear    = start_proc_pulse;
        state_nx = start_proc_pulse ? (gate ? WAIT_STEP : FETCH) : IDLE;
      end
`ifdef DS_FETCH_STEP_EN
      WAIT_STEP: state_nx = (step_pulse || !step_mode) ? FETCH : WAIT_STEP;
`endif
      FETCH:   state_nx = (mem_gnt && tap == 2'd3) ? DRAIN : FETCH;
      DRAIN:   state_nx = EMIT;
      EMIT: begin
        advance  = px_ready;
        state_nx = !px_ready ? EMIT : last ? DONE : gate ? WAIT_STEP : FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign mem_req  = state == FETCH;
  assign mem_addr = mem_req ? tap_addr : last_addr;
  assign px_valid = state == EMIT;
  assign busy     = state inside {WAIT_STEP, FETCH, DRAIN, EMIT};
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      state     <= IDLE;
      tap       <= '0;
      cap_v     <= 1'b0;
      cap_k     <= '0;
      last_addr <= '0;
      done      <= 1'b0;
      px00      <= '0;
      px01      <= '0;
      px10      <= '0;
      px11      <= '0;
    end else begin
      state     <= state_nx;
      tap       <= (mem_req && mem_gnt) ? tap + 2'd1 : tap;
      cap_v     <= mem_req && mem_gnt;
      cap_k     <= tap;
      last_addr <= mem_req ? tap_addr : last_addr;
      done      <= clear ? 1'b0 : (state_nx == DONE) ? 1'b1 : done;
      // read data lags the granted address by one cycle
      px00      <= (cap_v && cap_k == 2'd0) ? mem_data_out : px00;
      px01      <= (cap_v && cap_k == 2'd1) ? mem_data_out : px01;
      px10      <= (cap_v && cap_k == 2'd2) ? mem_data_out : px10;
      px11      <= (cap_v && cap_k == 2'd3) ? mem_data_out : px11;
    end
endmodule

// File: tb/tb_ds_pixel_fetch.sv
// tb_ds_pixel_fetch: scoreboard bench for ds_pixel_fetch on a 4x4 source image.
module tb_ds_pixel_fetch;
  typedef struct packed {
    logic [7:0] x, y, p00, p01, p10, p11;
  } exp_t;

  logic clk, aclr_n, start, step_mode, step_pulse, gnt, px_ready, alt, wrap_en;
  logic mem_req, px_valid, busy, done;
  logic [7:0] mem_addr, rdata, px00, px01, px10, px11;
  logic [0:0] px_x, px_y;
  logic mem_req_w, px_valid_w, busy_w, done_w;
  logic [7:0] mem_addr_w, rdata_w, px00_w, px01_w, px10_w, px11_w;
  logic [0:0] px_x_w, px_y_w;
  logic [45:0] outs;

  int checks = 0, failures = 0, n_xfer = 0;
  exp_t q[$], q_w[$];

  ds_pixel_fetch #(.ADDR_BITS(8), .SRC_W(4), .SRC_H(4), .BASE_ADDR(0)) dut (
    .clk(clk), .aclr_n(aclr_n), .start_proc_pulse(start), .step_mode(step_mode),
    .step_pulse(step_pulse), .mem_req(mem_req), .mem_gnt(gnt), .mem_addr(mem_addr),
    .mem_data_out(rdata), .px_valid(px_valid), .px_ready(px_ready),
    .px00(px00), .px01(px01), .px10(px10), .px11(px11),
    .px_x(px_x), .px_y(px_y), .busy(busy), .done(done)
  );

  ds_pixel_fetch #(.ADDR_BITS(8), .SRC_W(4), .SRC_H(4), .BASE_ADDR(254)) dut_w (
    .clk(clk), .aclr_n(aclr_n), .start_proc_pulse(start & wrap_en), .step_mode(1'b0),
    .step_pulse(1'b0), .mem_req(mem_req_w), .mem_gnt(1'b1), .mem_addr(mem_addr_w),
    .mem_data_out(rdata_w), .px_valid(px_valid_w), .px_ready(1'b1),
    .px00(px00_w), .px01(px01_w), .px10(px10_w), .px11(px11_w),
    .px_x(px_x_w), .px_y(px_y_w), .busy(busy_w), .done(done_w)
  );

  assign outs = {mem_req, mem_addr, px_valid, busy, done, px00, px01, px10, px11, px_x, px_y};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory[a] = a; a non-granted cycle returns foreign data
  always @(posedge clk) begin
    rdata   <= gnt ? mem_addr : 8'hEE;
    rdata_w <= mem_addr_w;
  end

  initial begin
    gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1 gnt = alt ? ~gnt : 1'b1;
    end
  end

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (px_valid && px_ready) begin
      n_xfer++;
      if (q.size() == 0) chk("xfer_unexpected", 64'(1), 64'(0));
      else chk("xfer", 64'(exp_t'{8'(px_x), 8'(px_y), px00, px01, px10, px11}), 64'(q.pop_front()));
    end
    if (px_valid_w) begin
      if (q_w.size() == 0) chk("wrap_unexpected", 64'(1), 64'(0));
      else chk("wrap_xfer", 64'(exp_t'{8'(px_x_w), 8'(px_y_w), px00_w, px01_w, px10_w, px11_w}),
               64'(q_w.pop_front()));
    end
  end

  task automatic push_run(int base, bit to_wrap);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        exp_t e;
        e.x   = 8'(x);
        e.y   = 8'(y);
        e.p00 = 8'(base + 8 * y + 2 * x);
        e.p01 = 8'(base + 8 * y + 2 * x + 1);
        e.p10 = 8'(base + 8 * y + 4 + 2 * x);
        e.p11 = 8'(base + 8 * y + 4 + 2 * x + 1);
        if (to_wrap) q_w.push_back(e);
        else q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_busy"}, 64'({done, busy}), 64'(2'b10));
    chk({name, "_xfers"}, 64'(n_xfer), 64'(4));
    chk({name, "_sb_empty"}, 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] taps[4] = '{8'd0, 8'd1, 8'd4, 8'd5};
    int cyc, n;
    logic seen;
    aclr_n = 0; start = 0; wrap_en = 1; step_mode = 0; step_pulse = 0; px_ready = 1; alt = 0;
    #1 chk("reset_outs", 64'(outs), 64'(0));
    repeat (2) @(posedge clk);
    #1 aclr_n = 1;
    @(posedge clk);
    #1;
    // basic run, with the wrap instance started alongside
    push_run(0, 0);
    push_run(254, 1);
    n_xfer = 0;
    pulse_start();
    wrap_en = 0;
    cyc = 1;
    @(negedge clk);
    while (!px_valid && cyc < 40) begin
      if (cyc <= 4) chk($sformatf("tap_addr%0d", cyc), 64'({mem_req, mem_addr}), 64'({1'b1, taps[cyc-1]}));
      @(negedge clk);
      cyc++;
    end
    chk("first_valid_cycle", 64'(cyc), 64'(6));
    wait_done("basic");
    chk("wrap_sb_empty", 64'(q_w.size()), 64'(0));
    // alternate grants, plus a start while busy that must be ignored
    push_run(0, 0);
    n_xfer = 0;
    alt = 1;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 pulse_start();
    wait_done("stall");
    alt = 0;
    repeat (3) @(posedge clk);
    #1 chk("done_held", 64'(done), 64'(1));
    // backpressure on the first output
    push_run(0, 0);
    n_xfer = 0;
    px_ready = 0;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!px_valid && n < 40);
    chk("done_cleared", 64'(done), 64'(0));
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 64'({mem_req, px_valid, px00, px01, px10, px11}),
          64'({1'b0, 1'b1, 8'd0, 8'd1, 8'd4, 8'd5}));
      @(negedge clk);
    end
    @(posedge clk);
    #1 px_ready = 1;
    wait_done("backpressure");
    // asynchronous reset while fetching the second pixel
    push_run(0, 0);
    n_xfer = 0;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(n_xfer == 1 && mem_req) && n < 100);
    chk("reset_reach", 64'({mem_req, mem_addr}), 64'({1'b1, 8'd2}));
    aclr_n = 0;
    #1 chk("async_reset", 64'(outs), 64'(0));
    q.delete();
    repeat (2) @(posedge clk);
    #1 aclr_n = 1;
    @(posedge clk);
    #1;
    push_run(0, 0);
    n_xfer = 0;
    pulse_start();
    wait_done("after_reset");
`ifdef DS_FETCH_STEP_EN
    step_mode = 1;
    push_run(0, 0);
    n_xfer = 0;
    pulse_start();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= mem_req;
    end
    chk("step_no_req", 64'(seen), 64'(0));
    @(posedge clk);
    #1 px_ready = 0; step_pulse = 1;
    @(posedge clk);
    #1 step_pulse = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!px_valid && n < 40);
    @(posedge clk);
    #1 step_pulse = 1;
    @(posedge clk);
    #1 step_pulse = 0; px_ready = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= mem_req;
    end
    chk("step_drop", 64'({seen, 8'(n_xfer)}), 64'({1'b0, 8'd1}));
    @(posedge clk);
    #1 step_pulse = 1;
    @(posedge clk);
    #1 step_pulse = 0;
    repeat (20) @(posedge clk);
    #1 chk("step_one_pixel", 64'(n_xfer), 64'(2));
    step_mode = 0;
    wait_done("step");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
